// File: rtl/otter_intr_csr_pkg.sv
// Shared CSR addresses, mstatus bit positions and cause base
// for the OTTER machine-mode CSR / interrupt block.
package otter_csr_pkg;

  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t CSR_MSTATUS = 12'h300;
  localparam csr_addr_t CSR_MIE     = 12'h304;
  localparam csr_addr_t CSR_MTVEC   = 12'h305;
  localparam csr_addr_t CSR_MEPC    = 12'h341;
  localparam csr_addr_t CSR_MCAUSE  = 12'h342;
  localparam csr_addr_t CSR_MIP     = 12'h344;

  localparam int MIE_BIT        = 3;
  localparam int MPIE_BIT       = 7;
  localparam int IRQ_CAUSE_BASE = 16;

  function automatic logic [31:0] word_align(
    input logic [31:0] v
  );
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_intr_csr_if.sv
// CSR access bus between CU_FSM/datapath (master)
// and the CSR file (slave).
interface otter_intr_csr_if;
  import otter_csr_pkg::*;

  csr_addr_t   CSR_ADDR;
  logic        CSR_WE;
  logic [31:0] CSR_WD;
  logic [31:0] CSR_RD;

  modport master (
    output CSR_ADDR, CSR_WE, CSR_WD,
    input  CSR_RD
  );

  modport slave (
    input  CSR_ADDR, CSR_WE, CSR_WD,
    output CSR_RD
  );

endinterface

// File: rtl/otter_intr_sync.sv
// Single-bit synchroniser followed by a rising-edge
// detector producing a one-cycle pulse.
module otter_intr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic src,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/otter_intr_csr.sv
// Machine-mode CSR file and multi-source interrupt controller.
// Optional vectored mtvec mode: define OTTER_INTR_VECTORED_EN.
module otter_intr_csr
  import otter_csr_pkg::*;
#(
  parameter int          N_SRC       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_SRC-1:0]  INTR_SRC,
  otter_intr_csr_if.slave   csr,
  input  logic [31:0]       PC,
  input  logic              INT_TAKEN,
  input  logic              MRET_EXEC,
  output logic              INTR_REQ,
  output logic [31:0]       MTVEC,
  output logic [31:0]       MEPC
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mie_q;
  logic [N_SRC-1:0] qual;
  logic [N_SRC-1:0] clr;
  logic [IW-1:0]    idx;
  logic             any_q;
  logic             mie_b;
  logic             mpie_b;
  logic [31:0]      mtvec_q;
  logic [31:0]      mepc_q;
  logic [31:0]      mcause_q;
  logic             we_mstatus;
  logic             we_mie;
  logic             we_mtvec;
  logic             we_mepc;
  logic             we_mcause;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    otter_intr_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .CLK  (CLK),
      .RST  (RST),
      .src  (INTR_SRC[i]),
      .rise (rise[i])
    );
  end

  // Lowest qualifying index wins
  always_comb begin
    qual = pending & mie_q;
    idx  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (qual[i]) idx = IW'(i);
    end
  end

  assign any_q    = |qual;
  assign INTR_REQ = mie_b & any_q;
  assign clr      = (INT_TAKEN && any_q)
                  ? (N_SRC'(1) << idx) : '0;

  assign we_mstatus = csr.CSR_WE
                    && (csr.CSR_ADDR == CSR_MSTATUS);
  assign we_mie     = csr.CSR_WE
                    && (csr.CSR_ADDR == CSR_MIE);
  assign we_mtvec   = csr.CSR_WE
                    && (csr.CSR_ADDR == CSR_MTVEC);
  assign we_mepc    = csr.CSR_WE
                    && (csr.CSR_ADDR == CSR_MEPC);
  assign we_mcause  = csr.CSR_WE
                    && (csr.CSR_ADDR == CSR_MCAUSE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending  <= '0;
      mie_q    <= '0;
      mie_b    <= 1'b0;
      mpie_b   <= 1'b0;
      mtvec_q  <= MTVEC_RST;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      // a new edge dominates the clear of the taken source
      pending <= (pending & ~clr) | rise;

      if (we_mie) mie_q <= csr.CSR_WD[N_SRC-1:0];

      if (we_mtvec) begin
`ifdef OTTER_INTR_VECTORED_EN
        mtvec_q <= csr.CSR_WD;
`else
        mtvec_q <= word_align(csr.CSR_WD);
`endif
      end

      if (INT_TAKEN) begin
        mpie_b <= mie_b;
        mie_b  <= 1'b0;
      end else if (MRET_EXEC) begin
        mie_b  <= mpie_b;
        mpie_b <= 1'b1;
      end else if (we_mstatus) begin
        mie_b  <= csr.CSR_WD[MIE_BIT];
        mpie_b <= csr.CSR_WD[MPIE_BIT];
      end

      if (INT_TAKEN) begin
        mepc_q <= word_align(PC);
      end else if (we_mepc) begin
        mepc_q <= word_align(csr.CSR_WD);
      end

      if (INT_TAKEN) begin
        if (any_q) begin
          mcause_q <= {1'b1,
            31'(IRQ_CAUSE_BASE) + 31'(idx)};
        end
      end else if (we_mcause) begin
        mcause_q <= csr.CSR_WD;
      end
    end
  end

  always_comb begin
    csr.CSR_RD = '0;
    case (csr.CSR_ADDR)
      CSR_MSTATUS: begin
        csr.CSR_RD[MIE_BIT]  = mie_b;
        csr.CSR_RD[MPIE_BIT] = mpie_b;
      end
      CSR_MIE:    csr.CSR_RD[N_SRC-1:0] = mie_q;
      CSR_MTVEC:  csr.CSR_RD = mtvec_q;
      CSR_MEPC:   csr.CSR_RD = mepc_q;
      CSR_MCAUSE: csr.CSR_RD = mcause_q;
      CSR_MIP:    csr.CSR_RD[N_SRC-1:0] = pending;
      default:    csr.CSR_RD = '0;
    endcase
  end

  always_comb begin
    MTVEC = word_align(mtvec_q);
`ifdef OTTER_INTR_VECTORED_EN
    if (INT_TAKEN && (mtvec_q[1:0] == 2'b01)) begin
      MTVEC = word_align(mtvec_q)
            + ((32'(IRQ_CAUSE_BASE) + 32'(idx)) << 2);
    end
`endif
  end

  assign MEPC = mepc_q;

endmodule

// File: tb/tb_otter_intr_csr.sv
// Self-checking bench for otter_intr_csr: spec-level model
// compared every cycle, plus directed literal checks.
module tb_otter_intr_csr;
  import otter_csr_pkg::*;

  localparam int          N  = 4;
  localparam int          S  = 2;
  localparam logic [31:0] RV = 32'h100;
`ifdef OTTER_INTR_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src;
  logic [31:0]   pc;
  logic          it;
  logic          mret;
  logic          req;
  logic [31:0]   mtvec_o;
  logic [31:0]   mepc_o;

  otter_intr_csr_if bus ();

  otter_intr_csr #(
    .N_SRC       (N),
    .SYNC_STAGES (S),
    .MTVEC_RST   (RV)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .INTR_SRC  (src),
    .csr       (bus.slave),
    .PC        (pc),
    .INT_TAKEN (it),
    .MRET_EXEC (mret),
    .INTR_REQ  (req),
    .MTVEC     (mtvec_o),
    .MEPC      (mepc_o)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model state: architectural CSRs plus raw input history
  bit          m_ie, m_pie;
  bit [N-1:0]  m_en, m_pend;
  bit [31:0]   m_tvec, m_epc, m_cause;
  bit [N-1:0]  m_hist [0:S];

  function automatic int first_q();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_rd(input logic [11:0] a);
    case (a)
      12'h300: return {24'b0, m_pie, 3'b0, m_ie, 3'b0};
      12'h304: return 32'(m_en);
      12'h305: return m_tvec;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h344: return 32'(m_pend);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_mtvec();
    int q;
    logic [31:0] base;
    base = m_tvec & 32'hFFFF_FFFC;
    if (VEC && it && m_tvec[1:0] == 2'b01) begin
      q = first_q();
      if (q < 0) q = 0;
      return base + 32'(4 * (16 + q));
    end
    return base;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit [N-1:0]  rise, pend, en;
    bit          ie, pie;
    bit [31:0]   epc, cause, tvec, wd;
    int          q;
    if (rst) begin
      m_ie <= 0; m_pie <= 0; m_en <= '0; m_pend <= '0;
      m_tvec <= RV; m_epc <= '0; m_cause <= '0;
      for (int i = 0; i <= S; i++) m_hist[i] <= '0;
    end else begin
      rise = m_hist[S-1] & ~m_hist[S];
      q = first_q();
      pend = m_pend; en = m_en; ie = m_ie; pie = m_pie;
      epc = m_epc; cause = m_cause; tvec = m_tvec;
      wd = bus.CSR_WD;
      if (bus.CSR_WE) begin
        case (bus.CSR_ADDR)
          12'h304: en = wd[N-1:0];
          12'h305: tvec = VEC ? wd : (wd & 32'hFFFF_FFFC);
          12'h300: if (!it && !mret) begin
                     ie = wd[3]; pie = wd[7];
                   end
          12'h341: if (!it) epc = wd & 32'hFFFF_FFFC;
          12'h342: if (!it) cause = wd;
          default: ;
        endcase
      end
      if (it) begin
        epc = pc & 32'hFFFF_FFFC;
        pie = m_ie;
        ie  = 0;
        if (q >= 0) begin
          cause = 32'h8000_0000 | 32'(16 + q);
          pend[q] = 0;
        end
      end else if (mret) begin
        ie  = m_pie;
        pie = 1;
      end
      pend = pend | rise;
      m_pend <= pend; m_en <= en; m_ie <= ie; m_pie <= pie;
      m_epc <= epc; m_cause <= cause; m_tvec <= tvec;
      m_hist[0] <= src;
      for (int i = 1; i <= S; i++) m_hist[i] <= m_hist[i-1];
    end
  end

  always @(negedge clk) begin
    chk("req", {31'b0, req},
        {31'b0, (m_ie && first_q() >= 0)});
    chk("csr_rd", bus.CSR_RD, m_rd(bus.CSR_ADDR));
    chk("mtvec_out", mtvec_o, m_mtvec());
    chk("mepc_out", mepc_o, m_epc);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [11:0] a,
                    input logic [31:0] d);
    bus.CSR_ADDR = a;
    bus.CSR_WE   = 1'b1;
    bus.CSR_WD   = d;
    step();
    bus.CSR_WE   = 1'b0;
  endtask

  task automatic rd(input string nm,
                    input logic [11:0] a,
                    input logic [31:0] exp);
    bus.CSR_ADDR = a;
    #1;
    chk(nm, bus.CSR_RD, exp);
  endtask

  task automatic trap(input logic [31:0] p);
    pc = p;
    it = 1'b1;
    step();
    it = 1'b0;
  endtask

  task automatic do_mret();
    mret = 1'b1;
    step();
    mret = 1'b0;
  endtask

  task automatic rd_reset(input string tag);
    rd({tag, "_mstatus"}, 12'h300, 32'h0);
    rd({tag, "_mie"},     12'h304, 32'h0);
    rd({tag, "_mtvec"},   12'h305, RV);
    rd({tag, "_mepc"},    12'h341, 32'h0);
    rd({tag, "_mcause"},  12'h342, 32'h0);
    rd({tag, "_mip"},     12'h344, 32'h0);
    chk({tag, "_req"}, {31'b0, req}, 32'h0);
    chk({tag, "_MTVEC"}, mtvec_o, RV);
  endtask

  initial begin
    rst = 1'b1; src = '0; pc = '0; it = 1'b0; mret = 1'b0;
    bus.CSR_ADDR = '0; bus.CSR_WE = 1'b0; bus.CSR_WD = '0;
    steps(2);
    rd_reset("in_rst");
    rst = 1'b0;
    step();
    rd_reset("post_rst");

    wr(12'h304, 32'h4);
    wr(12'h300, 32'h8);
    src = 4'b0100;
    step();
    src = '0;
    chk("lat_e0", {31'b0, req}, 32'h0);
    step();
    chk("lat_e1", {31'b0, req}, 32'h0);
    step();
    chk("lat_e2", {31'b0, req}, 32'h1);
    chk("direct_MTVEC", mtvec_o, 32'h100);
    trap(32'h2C);
    rd("t1_mepc", 12'h341, 32'h2C);
    rd("t1_mcause", 12'h342, 32'h8000_0012);
    rd("t1_mstatus", 12'h300, 32'h80);
    rd("t1_mip", 12'h344, 32'h0);
    chk("t1_req", {31'b0, req}, 32'h0);
    do_mret();
    rd("mret_mstatus", 12'h300, 32'h88);

    wr(12'h300, 32'h0);
    wr(12'h304, 32'hA);
    src = 4'b1011;
    step();
    src = '0;
    steps(2);
    rd("pri_mip", 12'h344, 32'hB);
    chk("pri_masked_req", {31'b0, req}, 32'h0);
    wr(12'h300, 32'h8);
    chk("pri_req", {31'b0, req}, 32'h1);
    trap(32'h40);
    rd("pri_cause1", 12'h342, 32'h8000_0011);
    rd("pri_mip1", 12'h344, 32'h9);
    do_mret();
    chk("pri_rearm", {31'b0, req}, 32'h1);
    trap(32'h44);
    rd("pri_cause3", 12'h342, 32'h8000_0013);
    rd("pri_mip3", 12'h344, 32'h1);
    do_mret();
    rd("src0_held", 12'h344, 32'h1);
    chk("src0_noreq", {31'b0, req}, 32'h0);

    pc = 32'h80; it = 1'b1;
    bus.CSR_ADDR = 12'h341; bus.CSR_WE = 1'b1;
    bus.CSR_WD = 32'h400;
    step();
    it = 1'b0; bus.CSR_WE = 1'b0;
    rd("col_mepc", 12'h341, 32'h80);
    rd("col_mcause", 12'h342, 32'h8000_0013);
    do_mret();
    pc = 32'h84; it = 1'b1; mret = 1'b1;
    step();
    it = 1'b0; mret = 1'b0;
    rd("it_mret", 12'h300, 32'h80);
    do_mret();

    wr(12'h304, 32'h4);
    src = 4'b0100;
    step();
    src = '0;
    step();
    src = 4'b0100;
    step();
    src = '0;
    chk("col_req", {31'b0, req}, 32'h1);
    step();
    trap(32'h90);
    rd("col_mip", 12'h344, 32'h5);
    rd("col_cause", 12'h342, 32'h8000_0012);
    do_mret();
    chk("col_again", {31'b0, req}, 32'h1);
    trap(32'h94);
    rd("col_mip2", 12'h344, 32'h1);
    do_mret();

    src = 4'b0100;
    steps(3);
    chk("hold_req", {31'b0, req}, 32'h1);
    trap(32'h98);
    do_mret();
    steps(4);
    chk("hold_once", {31'b0, req}, 32'h0);
    rd("hold_mip", 12'h344, 32'h1);
    src = '0;
    steps(3);

    wr(12'h304, 32'h2);
    wr(12'h305, 32'h201);
    rd("vec_mtvec", 12'h305, VEC ? 32'h201 : 32'h200);
    chk("vec_idle", mtvec_o, 32'h200);
    src = 4'b0010;
    step();
    src = '0;
    steps(2);
    pc = 32'hA0; it = 1'b1;
    #1;
    chk("vec_MTVEC", mtvec_o, VEC ? 32'h244 : 32'h200);
    step();
    it = 1'b0;
    rd("vec_cause", 12'h342, 32'h8000_0011);
    do_mret();

    wr(12'h341, 32'h403);
    rd("mepc_align", 12'h341, 32'h400);
    wr(12'h344, 32'hF);
    rd("mip_ro", 12'h344, 32'h1);
    wr(12'h123, 32'hFFFF_FFFF);
    rd("unmapped", 12'h123, 32'h0);
    wr(12'h342, 32'h1234_5678);
    rd("mcause_wr", 12'h342, 32'h1234_5678);

    src = 4'b0001;
    pc = 32'h50; it = 1'b1; rst = 1'b1;
    step();
    it = 1'b0; src = '0;
    rd_reset("mid_rst");
    rst = 1'b0;
    steps(3);
    rd_reset("end");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/otter_intr_csr.md
Name: otter_intr_csr

Overview:
- Parametrised machine-mode CSR file and multi-source interrupt controller for the multicycle OTTER MCU.
- Replaces the constant MTVEC, MEPC, csr_RD, int_taken and single-INTR stubs in the MCU top level.
- Synchronises N_SRC external interrupt lines, latches rising edges as pending, and raises one interrupt request to CU_FSM.
- Holds mstatus/mie/mtvec/mepc/mcause/mip and performs the trap-entry and mret state updates.

Parameters:
N_SRC, 4, number of external interrupt sources (1..16)
SYNC_STAGES, 2, synchroniser flops per source (>=2)
MTVEC_RST, 32'h0000_0000, reset value of mtvec

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  asynchronous active-high reset
INTR_SRC  in  N_SRC  asynchronous interrupt lines, rising-edge sensitive
CSR_ADDR  in  12  CSR address, ir[31:20]
CSR_WE  in  1  CSR write strobe from CU_FSM
CSR_WD  in  32  CSR write data (ALU result)
PC  in  32  PC of the instruction to resume; captured into mepc on trap
INT_TAKEN  in  1  one-cycle pulse from CU_FSM: trap entry this cycle
MRET_EXEC  in  1  one-cycle pulse from CU_FSM: mret executing
INTR_REQ  out  1  interrupt request to CU_FSM
CSR_RD  out  32  read data for CSR_ADDR, combinational
MTVEC  out  32  trap target for PC mux
MEPC  out  32  return target for PC mux

Behaviour:
- Reset (async, RST=1): mstatus=0, mie=0, mtvec=MTVEC_RST, mepc=0, mcause=0, pending=0, all sync/edge flops=0.
- Outputs under reset: INTR_REQ=0, MEPC=0, MTVEC=MTVEC_RST.
- Reset asserted mid-trap clears everything; there is no partial state.
- CSR map:
  - 0x300 mstatus: bit3 MIE, bit7 MPIE; other bits read 0.
  - 0x304 mie: bits [N_SRC-1:0] writable.
  - 0x305 mtvec.
  - 0x341 mepc: bits[1:0] forced 0 on every write.
  - 0x342 mcause: writable.
  - 0x344 mip: read-only pending[N_SRC-1:0]; writes ignored.
- Unmapped address: CSR_RD=0, write ignored. Write takes effect at the CLK edge where CSR_WE=1.
- Input path: each INTR_SRC bit passes SYNC_STAGES flops, then one flop for edge detect. A synchronised 0->1 sets pending[i].
- Latency: rising edge on INTR_SRC before edge k sets pending, and INTR_REQ if enabled, after edge k+SYNC_STAGES.
- Level-high input sets pending exactly once. It re-arms only after the line falls.
- INTR_REQ = mstatus.MIE & |(pending & mie[N_SRC-1:0]), combinational from registers.
- Masked sources stay pending and fire when enabled.
- Priority: lowest index among (pending & mie) wins; idx = that index.
- INT_TAKEN=1 at an edge:
  - mepc<=PC with [1:0]=0.
  - mcause<={1'b1, 31'(16+idx)}.
  - MPIE<=MIE, MIE<=0.
  - pending[idx]<=0.
  - If no source qualifies, only mepc and mstatus update.
- MRET_EXEC=1: MIE<=MPIE, MPIE<=1.
- Simultaneous events:
  - INT_TAKEN with MRET_EXEC: INT_TAKEN wins, MRET ignored.
  - INT_TAKEN with CSR_WE to mstatus/mepc/mcause: trap update wins for that register. Writes to other CSRs proceed.
  - MRET_EXEC with CSR_WE to mstatus: MRET wins.
  - New edge on source i in the same cycle pending[i] is cleared: set dominates, so the edge is not lost.
- MTVEC output = mtvec with [1:0] masked to 0 (direct mode).

Optional Feature:
- Macro OTTER_INTR_VECTORED_EN.
- Defined:
  - mtvec[1:0] writable.
  - When mtvec[1:0]==2'b01 during INT_TAKEN, MTVEC output = {mtvec[31:2],2'b00} + 4*(16+idx), using the idx selected that cycle.
  - At all other times MTVEC output = {mtvec[31:2],2'b00}.
- Undefined: mtvec[1:0] always written as 00; direct mode only.

Decomposition:
- Package otter_csr_pkg holds:
  - CSR address localparams (CSR_MSTATUS=12'h300, etc.).
  - mstatus bit indices MIE_BIT=3, MPIE_BIT=7.
  - IRQ_CAUSE_BASE=16.
  - Typedef csr_addr_t (12 bits).
- One sub-module: otter_intr_sync, parametrised by SYNC_STAGES.
  - Single-bit synchroniser plus rising-edge detector; outputs a one-cycle pulse.
  - Instantiated N_SRC times via generate.

Test Plan:
- Reset: RST=1 with MTVEC_RST=32'h100 -> all CSRs read 0 except mtvec=32'h100; INTR_REQ=0 during and after reset.
- Enable and fire: write mie=4'b0100 and mstatus=32'h8; pulse INTR_SRC[2] -> INTR_REQ=1 exactly SYNC_STAGES+1 edges later.
  - Then INT_TAKEN with PC=32'h2C -> mepc=32'h2C, mcause=32'h8000_0012, mstatus=32'h80, mip=0, INTR_REQ=0.
- Priority and masking: pending sources 1 and 3 with mie=4'b1010 -> cause 0x11 taken first, then after MRET cause 0x13.
  - Source 0 pending with mie[0]=0 -> stays in mip, no request.
- MRET restore: after a trap, MRET_EXEC -> mstatus=32'h88, INTR_REQ re-asserts if a further source is pending.
- Collisions:
  - INT_TAKEN with CSR_WE to mepc=32'h400 -> mepc=PC.
  - New edge on a source coinciding with its clear -> mip bit remains 1.
  - Held-high source -> only one trap.
- Vectored (OTTER_INTR_VECTORED_EN): mtvec=32'h201, source 1 taken -> MTVEC=32'h244.
  - Without the macro, reading back that mtvec gives 32'h200 and MTVEC=32'h200.
